calc_stream_controller: RTL and testbench

CALC_STREAM_CONTROLLER -- requirements
Module: calc_stream_controller

---
 rtl/calc_stream_controller.sv | 190 +++++++++++++++++++
 tb/tb_calc_stream_controller.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_stream_controller.sv
// Streaming two-operand calculator: reads operand pairs from a read-address
// range, applies one ALU op, packs PACK results per word and writes them out.
module calc_stream_controller #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned PACK   = 2,
   parameter int unsigned RD_LAT = 1
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     start_i,
   input  logic [1:0]               op_i,
   input  logic [ADDR_W-1:0]        read_start_addr,
   input  logic [ADDR_W-1:0]        read_end_addr,
   input  logic [ADDR_W-1:0]        write_start_addr,
   input  logic [ADDR_W-1:0]        write_end_addr,
   output logic                     read,
   output logic [ADDR_W-1:0]        r_addr,
   input  logic [2*DATA_W-1:0]      r_data,
   output logic                     write,
   output logic [ADDR_W-1:0]        w_addr,
   output logic [PACK*DATA_W-1:0]   w_data,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     err_o,
   output logic                     ovf_o
);

   // Pointers carry one extra bit so an end address of all-ones terminates.
   localparam int unsigned PW    = ADDR_W + 1;
   localparam int unsigned IDX_W = $clog2(PACK + 1);
   localparam int unsigned CNT_W = 2;

   typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_EXEC, S_WRITE, S_DONE} state_t;

   state_t                   r_state;
   logic [1:0]               r_op;
   logic [PW-1:0]            r_rd_end;
   logic [PW-1:0]            r_wr_end;
   logic [PW-1:0]            r_rptr;
   logic [PW-1:0]            r_wptr;
   logic [IDX_W-1:0]         r_idx;
   logic [CNT_W-1:0]         r_wait;
   logic [PACK*DATA_W-1:0]   r_lanes;

   logic [DATA_W-1:0]        w_a;
   logic [DATA_W-1:0]        w_b;
   logic [DATA_W:0]          w_sum;
   logic [DATA_W-1:0]        w_res;
   logic                     w_ovf;
   logic [PACK*DATA_W-1:0]   w_lanes_nxt;
   logic [IDX_W-1:0]         w_idx_nxt;
   logic [PW-1:0]            w_rptr_nxt;
   logic                     w_full;
   logic                     w_last_rd;

   assign w_a        = r_data[DATA_W-1:0];
   assign w_b        = r_data[2*DATA_W-1:DATA_W];
   assign w_sum      = {1'b0, w_a} + {1'b0, w_b};
   assign w_idx_nxt  = r_idx + IDX_W'(1);
   assign w_rptr_nxt = r_rptr + PW'(1);
   assign w_full     = (w_idx_nxt == IDX_W'(PACK));
   assign w_last_rd  = (r_rptr == r_rd_end);

   // ALU result and per-operation overflow flag
   always_comb begin
      w_res = '0;
      w_ovf = 1'b0;
      case (r_op)
         2'b00: begin w_res = w_sum[DATA_W-1:0]; w_ovf = w_sum[DATA_W]; end
         2'b01: begin w_res = w_a - w_b;         w_ovf = (w_a < w_b);   end
         2'b10: w_res = (w_a < w_b) ? w_a : w_b;
         default: w_res = (w_a > w_b) ? w_a : w_b;
      endcase
   end

   // Lane vector with the current result dropped into slot r_idx
   always_comb begin
      w_lanes_nxt = r_lanes;
      for (int unsigned k = 0; k < PACK; k++) begin
         if (r_idx == IDX_W'(k)) w_lanes_nxt[k*DATA_W +: DATA_W] = w_res;
      end
   end

   // Job FSM with registered strobes and status
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= S_IDLE;
         r_op     <= '0;
         r_rd_end <= '0;
         r_wr_end <= '0;
         r_rptr   <= '0;
         r_wptr   <= '0;
         r_idx    <= '0;
         r_wait   <= '0;
         r_lanes  <= '0;
         read     <= 1'b0;
         r_addr   <= '0;
         write    <= 1'b0;
         w_addr   <= '0;
         w_data   <= '0;
         busy_o   <= 1'b0;
         done_o   <= 1'b0;
         err_o    <= 1'b0;
         ovf_o    <= 1'b0;
      end else begin
         read   <= 1'b0;
         write  <= 1'b0;
         done_o <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_op     <= op_i;
                  r_rd_end <= {1'b0, read_end_addr};
                  r_wr_end <= {1'b0, write_end_addr};
                  r_rptr   <= {1'b0, read_start_addr};
                  r_wptr   <= {1'b0, write_start_addr};
                  r_idx    <= '0;
                  r_lanes  <= '0;
                  err_o    <= 1'b0;
                  ovf_o    <= 1'b0;
                  if (read_start_addr > read_end_addr) begin
                     r_state <= S_DONE;
                     done_o  <= 1'b1;
                  end else begin
                     r_state <= S_READ;
                     read    <= 1'b1;
                     r_addr  <= read_start_addr;
                     busy_o  <= 1'b1;
                  end
               end
            end
            S_READ: begin
               if (RD_LAT > 1) begin
                  r_state <= S_WAIT;
                  r_wait  <= CNT_W'(RD_LAT - 2);
               end else begin
                  r_state <= S_EXEC;
               end
            end
            S_WAIT: begin
               if (r_wait == '0) r_state <= S_EXEC;
               else              r_wait  <= r_wait - CNT_W'(1);
            end
            S_EXEC: begin
               r_lanes <= w_lanes_nxt;
               ovf_o   <= ovf_o | w_ovf;
               r_idx   <= w_idx_nxt;
               r_rptr  <= w_rptr_nxt;
               if (w_full || w_last_rd) begin
                  r_state <= S_WRITE;
                  if (r_wptr <= r_wr_end) begin
                     write  <= 1'b1;
                     w_addr <= r_wptr[ADDR_W-1:0];
                     w_data <= w_lanes_nxt;
                  end
               end else begin
                  r_state <= S_READ;
                  read    <= 1'b1;
                  r_addr  <= w_rptr_nxt[ADDR_W-1:0];
               end
            end
            S_WRITE: begin
               r_lanes <= '0;
               r_idx   <= '0;
               if (r_wptr > r_wr_end) begin
                  err_o   <= 1'b1;
                  r_state <= S_DONE;
                  done_o  <= 1'b1;
                  busy_o  <= 1'b0;
               end else begin
                  r_wptr <= r_wptr + PW'(1);
                  if (r_rptr > r_rd_end) begin
                     r_state <= S_DONE;
                     done_o  <= 1'b1;
                     busy_o  <= 1'b0;
                  end else begin
                     r_state <= S_READ;
                     read    <= 1'b1;
                     r_addr  <= r_rptr[ADDR_W-1:0];
                  end
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_calc_stream_controller.sv
// Directed bench: one PACK=2/RD_LAT=1 instance and one PACK=1/RD_LAT=3 instance,
// a shared operand memory and per-instance write scoreboards.
module tb_calc_stream_controller;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 10;

   typedef struct {
      logic [AW-1:0] addr;
      logic [63:0]   data;
   } wr_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start_a = 1'b0;
   logic start_c = 1'b0;
   logic [1:0] op = 2'b00;
   logic [AW-1:0] rs = '0, re = '0, ws = '0, we = '0;

   logic read_a, write_a, busy_a, done_a, err_a, ovf_a;
   logic [AW-1:0] r_addr_a, w_addr_a;
   logic [2*DW-1:0] w_data_a;
   logic [2*DW-1:0] rdata_a;

   logic read_c, write_c, busy_c, done_c, err_c, ovf_c;
   logic [AW-1:0] r_addr_c, w_addr_c;
   logic [DW-1:0] w_data_c;
   logic [2*DW-1:0] p_c [3];

   logic [63:0] mem [1024];
   wr_t q_a[$];
   wr_t q_c[$];
   int n_vec = 0;
   int n_err = 0;
   int rd_a = 0, wr_a = 0, rd_c = 0, wr_c = 0;

   always #5 clk = ~clk;

   calc_stream_controller #(.DATA_W(DW), .ADDR_W(AW), .PACK(2), .RD_LAT(1)) u_dut_a (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .op_i(op),
      .read_start_addr(rs), .read_end_addr(re), .write_start_addr(ws), .write_end_addr(we),
      .read(read_a), .r_addr(r_addr_a), .r_data(rdata_a),
      .write(write_a), .w_addr(w_addr_a), .w_data(w_data_a),
      .busy_o(busy_a), .done_o(done_a), .err_o(err_a), .ovf_o(ovf_a));

   calc_stream_controller #(.DATA_W(DW), .ADDR_W(AW), .PACK(1), .RD_LAT(3)) u_dut_c (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start_c), .op_i(op),
      .read_start_addr(rs), .read_end_addr(re), .write_start_addr(ws), .write_end_addr(we),
      .read(read_c), .r_addr(r_addr_c), .r_data(p_c[2]),
      .write(write_c), .w_addr(w_addr_c), .w_data(w_data_c),
      .busy_o(busy_c), .done_o(done_c), .err_o(err_c), .ovf_o(ovf_c));

   // Memory models: one-cycle and three-cycle read latency
   always @(posedge clk) begin
      if (read_a) rdata_a <= mem[r_addr_a];
      p_c[0] <= read_c ? mem[r_addr_c] : 64'h0;
      p_c[1] <= p_c[0];
      p_c[2] <= p_c[1];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Strobe monitor and write scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         chk("rw_exclusive", 64'(((read_a && write_a) || (read_c && write_c)) ? 1 : 0), 64'd0);
         if (read_a) rd_a++;
         if (read_c) rd_c++;
         if (write_a) begin
            wr_a++;
            chk("wr_a_expected", 64'(q_a.size() != 0), 64'd1);
            if (q_a.size() != 0) begin
               wr_t e;
               e = q_a.pop_front();
               chk("wr_a_addr", 64'(w_addr_a), 64'(e.addr));
               chk("wr_a_data", w_data_a, e.data);
            end
         end
         if (write_c) begin
            wr_c++;
            chk("wr_c_expected", 64'(q_c.size() != 0), 64'd1);
            if (q_c.size() != 0) begin
               wr_t e;
               e = q_c.pop_front();
               chk("wr_c_addr", 64'(w_addr_c), 64'(e.addr));
               chk("wr_c_data", 64'(w_data_c), e.data);
            end
         end
      end
   end

   task automatic push_a(input int a, input logic [63:0] d);
      wr_t e;
      e.addr = AW'(a);
      e.data = d;
      q_a.push_back(e);
   endtask

   task automatic push_c(input int a, input logic [63:0] d);
      wr_t e;
      e.addr = AW'(a);
      e.data = d;
      q_c.push_back(e);
   endtask

   // Launch one job, scramble inputs mid-job, wait for done; lat counts cycles after the start edge
   task automatic run_job(input bit sel_c, input logic [1:0] o, input int a0, input int a1,
                          input int b0, input int b1, input int hold,
                          output int lat, output int nrd, output int nwr);
      int r0, w0;
      logic dn, bz;
      r0 = sel_c ? rd_c : rd_a;
      w0 = sel_c ? wr_c : wr_a;
      @(negedge clk);
      op = o; rs = AW'(a0); re = AW'(a1); ws = AW'(b0); we = AW'(b1);
      if (sel_c) start_c = 1'b1; else start_a = 1'b1;
      @(negedge clk);
      lat = 1;
      bz = sel_c ? busy_c : busy_a;
      chk("busy_after_start", 64'(bz), 64'(a0 <= a1));
      op = ~o; rs = AW'($urandom); re = AW'($urandom); ws = AW'($urandom); we = AW'($urandom);
      dn = sel_c ? done_c : done_a;
      while (!dn && lat < 200) begin
         if (lat >= hold) begin start_a = 1'b0; start_c = 1'b0; end
         @(negedge clk);
         lat++;
         dn = sel_c ? done_c : done_a;
      end
      start_a = 1'b0; start_c = 1'b0;
      chk("done_seen", 64'(dn), 64'd1);
      @(negedge clk);
      chk("done_one_cycle", 64'(sel_c ? done_c : done_a), 64'd0);
      chk("busy_after_done", 64'(sel_c ? busy_c : busy_a), 64'd0);
      nrd = (sel_c ? rd_c : rd_a) - r0;
      nwr = (sel_c ? wr_c : wr_a) - w0;
   endtask

   initial begin
      int lat, nrd, nwr, r0;
      mem[0] = {32'd2, 32'd1};
      mem[1] = {32'd4, 32'd3};
      mem[2] = {32'd6, 32'd5};
      mem[3] = {32'd8, 32'd7};
      mem[4] = {32'd1, 32'd0};
      mem[5] = {32'hFFFF_FFFF, 32'd1};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_a_ctrl", 64'({read_a, write_a, busy_a, done_a, err_a, ovf_a, r_addr_a, w_addr_a}), 64'd0);
      chk("rst_a_wdata", w_data_a, 64'd0);
      chk("rst_c_all", 64'({read_c, write_c, busy_c, done_c, err_c, ovf_c, r_addr_c, w_addr_c, w_data_c}), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Add over four words into two packed writes
      push_a(10, {32'd7, 32'd3});
      push_a(11, {32'd15, 32'd11});
      run_job(1'b0, 2'b00, 0, 3, 10, 11, 1, lat, nrd, nwr);
      chk("add4_latency_le13", 64'(lat <= 13), 64'd1);
      chk("add4_reads", 64'(nrd), 64'd4);
      chk("add4_writes", 64'(nwr), 64'd2);
      chk("add4_err", 64'(err_a), 64'd0);
      chk("add4_ovf", 64'(ovf_a), 64'd0);

      // Odd word count leaves the upper lane empty
      push_a(10, {32'd7, 32'd3});
      push_a(11, {32'd0, 32'd11});
      run_job(1'b0, 2'b00, 0, 2, 10, 11, 1, lat, nrd, nwr);
      chk("add3_writes", 64'(nwr), 64'd2);
      chk("add3_err", 64'(err_a), 64'd0);

      // Sub borrow wraps and flags overflow
      push_a(20, {32'd0, 32'hFFFF_FFFF});
      run_job(1'b0, 2'b01, 4, 4, 20, 20, 1, lat, nrd, nwr);
      chk("sub_borrow_ovf", 64'(ovf_a), 64'd1);

      // Min clears the previous job's overflow
      push_a(21, {32'd3, 32'd1});
      run_job(1'b0, 2'b10, 0, 1, 21, 21, 1, lat, nrd, nwr);
      chk("min_ovf_clear", 64'(ovf_a), 64'd0);

      // Max, then add carry-out wrapping to zero
      push_a(22, {32'd4, 32'd2});
      run_job(1'b0, 2'b11, 0, 1, 22, 22, 1, lat, nrd, nwr);
      chk("max_ovf", 64'(ovf_a), 64'd0);
      push_a(23, {32'd0, 32'd0});
      run_job(1'b0, 2'b00, 5, 5, 23, 23, 1, lat, nrd, nwr);
      chk("add_carry_ovf", 64'(ovf_a), 64'd1);

      // Empty read range: immediate done, no strobes
      run_job(1'b0, 2'b00, 4, 3, 0, 9, 1, lat, nrd, nwr);
      chk("empty_latency", 64'(lat), 64'd1);
      chk("empty_reads", 64'(nrd), 64'd0);
      chk("empty_writes", 64'(nwr), 64'd0);

      // Write range overrun on the PACK=1 instance
      push_c(5, 64'd3);
      run_job(1'b1, 2'b00, 0, 1, 5, 5, 1, lat, nrd, nwr);
      chk("ovr_writes", 64'(nwr), 64'd1);
      chk("ovr_reads", 64'(nrd), 64'd2);
      chk("ovr_err", 64'(err_c), 64'd1);

      // Start held high mid-job is ignored; err cleared by the new start
      push_c(6, 64'd3);
      push_c(7, 64'd7);
      run_job(1'b1, 2'b00, 0, 1, 6, 7, 6, lat, nrd, nwr);
      chk("hold_writes", 64'(nwr), 64'd2);
      chk("hold_err", 64'(err_c), 64'd0);

      // Reset during S_WAIT aborts immediately
      @(negedge clk);
      op = 2'b00; rs = AW'(2); re = AW'(3); ws = AW'(8); we = AW'(11);
      start_c = 1'b1;
      repeat (2) @(negedge clk);
      chk("pre_rst_busy", 64'(busy_c), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_c", 64'({read_c, write_c, busy_c, done_c, err_c, ovf_c, r_addr_c, w_addr_c, w_data_c}), 64'd0);
      chk("mid_rst_a_ctrl", 64'({read_a, write_a, busy_a, done_a, err_a, ovf_a, r_addr_a, w_addr_a}), 64'd0);
      chk("mid_rst_a_wdata", w_data_a, 64'd0);
      start_c = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      r0 = rd_c + wr_c;
      repeat (20) @(negedge clk);
      chk("post_rst_idle_busy", 64'(busy_c), 64'd0);
      chk("post_rst_no_strobes", 64'(rd_c + wr_c - r0), 64'd0);
      chk("sb_a_drained", 64'(q_a.size()), 64'd0);
      chk("sb_c_drained", 64'(q_c.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
